// File: rtl/ir_nec_pkg.sv
// Shared NEC IR definitions: tick constants, transmitter state encoding,
// remote scan codes and the frame-building helper used by TX and RX.
package ir_nec_pkg;

   localparam int NEC_TICK_CYCLES      = 1750;
   localparam int NEC_LEAD_MARK_TICKS  = 257;
   localparam int NEC_LEAD_SPACE_TICKS = 128;
   localparam int NEC_REP_SPACE_TICKS  = 64;
   localparam int NEC_BIT_MARK_TICKS   = 16;
   localparam int NEC_ZERO_SPACE_TICKS = 16;
   localparam int NEC_ONE_SPACE_TICKS  = 48;
   localparam int NEC_GAP_TICKS        = 1143;
   localparam int NEC_CARRIER_HALF     = 658;

   // Wide enough for the longest phase (GAP).
   localparam int NEC_TICK_W = 12;

   typedef enum logic [2:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      BIT_MARK,
      BIT_SPACE,
      STOP_MARK,
      GAP
   } txState_t;

   localparam logic [7:0] CHANNEL_MINUS = 8'hA2;
   localparam logic [7:0] CHANNEL       = 8'h62;
   localparam logic [7:0] CHANNEL_PLUS  = 8'hE2;
   localparam logic [7:0] PREV          = 8'h22;
   localparam logic [7:0] NEXT          = 8'h02;
   localparam logic [7:0] PLAY_PAUSE    = 8'hC2;
   localparam logic [7:0] VOL_MINUS     = 8'hE0;
   localparam logic [7:0] VOL_PLUS      = 8'hA8;
   localparam logic [7:0] EQ            = 8'h90;
   localparam logic [7:0] N0            = 8'h68;
   localparam logic [7:0] N1            = 8'h30;
   localparam logic [7:0] N2            = 8'h18;
   localparam logic [7:0] N3            = 8'h7A;
   localparam logic [7:0] N4            = 8'h10;
   localparam logic [7:0] N5            = 8'h38;
   localparam logic [7:0] N6            = 8'h5A;
   localparam logic [7:0] N7            = 8'h42;
   localparam logic [7:0] N8            = 8'h4A;
   localparam logic [7:0] N9            = 8'h52;

   // Address and command each followed by their inverse, sent MSB first.
   function automatic logic [31:0] necFrame(input logic [7:0] addr, input logic [7:0] cmd);
      return {addr, ~addr, cmd, ~cmd};
   endfunction

   // Phases during which the LED envelope is lit.
   function automatic logic isMarkState(input txState_t s);
      return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
   endfunction

endpackage

// File: rtl/ir_nec_tx_if.sv
// Request/status bundle between the front-panel controller and the NEC transmitter.
interface ir_nec_tx_if;
   logic       start;
   logic       repeatReq;
   logic [7:0] address;
   logic [7:0] command;
   logic       irEnv;
   logic       irOut;
   logic       busy;
   logic       done;

   modport master (
      output start, repeatReq, address, command,
      input  irEnv, irOut, busy, done
   );

   modport slave (
      input  start, repeatReq, address, command,
      output irEnv, irOut, busy, done
   );
endinterface

// File: rtl/ir_tick_timer.sv
// Phase timer: a prescaler producing slow ticks and a tick counter compared
// against the current phase length. Both sit at zero while idle and restart
// from zero on the cycle after a phase ends.
module ir_tick_timer
   import ir_nec_pkg::*;
#(
   parameter int TICK_CYCLES = NEC_TICK_CYCLES,
   parameter int TW          = NEC_TICK_W
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic [TW-1:0] loadTicks,
   output logic          phaseEnd
);

   localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

   logic [PRE_W-1:0] presc;
   logic [TW-1:0]    ticks;
   logic             preWrap;

   assign preWrap  = (presc == PRE_LAST);
   assign phaseEnd = run && preWrap && (ticks == (loadTicks - TW'(1)));

   // Count clk cycles into ticks; clear on idle and at every phase boundary.
   always_ff @(posedge clk) begin
      if (rst || !run || phaseEnd) begin
         presc <= '0;
         ticks <= '0;
      end else if (preWrap) begin
         presc <= '0;
         ticks <= ticks + TW'(1);
      end else begin
         presc <= presc + PRE_W'(1);
      end
   end

endmodule

// File: rtl/ir_nec_tx.sv
// NEC IR transmitter: sends a 32-bit address/command frame or a repeat code
// as a mark/space envelope, optionally modulated onto a carrier.
module ir_nec_tx
   import ir_nec_pkg::*;
#(
   parameter int TICK_CYCLES      = NEC_TICK_CYCLES,
   parameter int LEAD_MARK_TICKS  = NEC_LEAD_MARK_TICKS,
   parameter int LEAD_SPACE_TICKS = NEC_LEAD_SPACE_TICKS,
   parameter int REP_SPACE_TICKS  = NEC_REP_SPACE_TICKS,
   parameter int BIT_MARK_TICKS   = NEC_BIT_MARK_TICKS,
   parameter int ZERO_SPACE_TICKS = NEC_ZERO_SPACE_TICKS,
   parameter int ONE_SPACE_TICKS  = NEC_ONE_SPACE_TICKS,
   parameter int GAP_TICKS        = NEC_GAP_TICKS,
   parameter int CARRIER_HALF     = NEC_CARRIER_HALF
)(
   input logic         clk,
   input logic         rst,
   ir_nec_tx_if.slave  bus
);

   localparam int TW = NEC_TICK_W;

   txState_t      state;
   txState_t      nextState;
   logic [31:0]   shift;
   logic [5:0]    bitCnt;
   logic          isRepeat;
   logic [TW-1:0] loadTicks;
   logic          phaseEnd;
   logic          accept;
   logic          envReg;
   logic          busyReg;
   logic          carrier;
   logic [15:0]   carrierCnt;

   ir_tick_timer #(
      .TICK_CYCLES (TICK_CYCLES),
      .TW          (TW)
   ) timer (
      .clk       (clk),
      .rst       (rst),
      .run       (state != IDLE),
      .loadTicks (loadTicks),
      .phaseEnd  (phaseEnd)
   );

   // Next-state logic and the tick length of the current phase.
   always_comb begin
      nextState = state;
      loadTicks = TW'(1);
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start || bus.repeatReq) begin
               accept    = 1'b1;
               nextState = LEAD_MARK;
            end
         end
         LEAD_MARK: begin
            loadTicks = TW'(LEAD_MARK_TICKS);
            if (phaseEnd) nextState = LEAD_SPACE;
         end
         LEAD_SPACE: begin
            loadTicks = isRepeat ? TW'(REP_SPACE_TICKS) : TW'(LEAD_SPACE_TICKS);
            if (phaseEnd) nextState = isRepeat ? STOP_MARK : BIT_MARK;
         end
         BIT_MARK: begin
            loadTicks = TW'(BIT_MARK_TICKS);
            if (phaseEnd) nextState = BIT_SPACE;
         end
         BIT_SPACE: begin
            loadTicks = shift[31] ? TW'(ONE_SPACE_TICKS) : TW'(ZERO_SPACE_TICKS);
            if (phaseEnd) nextState = (bitCnt == 6'd31) ? STOP_MARK : BIT_MARK;
         end
         STOP_MARK: begin
            loadTicks = TW'(BIT_MARK_TICKS);
            if (phaseEnd) nextState = GAP;
         end
         GAP: begin
            loadTicks = TW'(GAP_TICKS);
            if (phaseEnd) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   // Capture the frame on acceptance and shift it out one bit per data space.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift    <= '0;
         bitCnt   <= '0;
         isRepeat <= 1'b0;
      end else if (accept) begin
         shift    <= necFrame(bus.address, bus.command);
         bitCnt   <= '0;
         isRepeat <= bus.repeatReq && !bus.start;
      end else if (state == LEAD_SPACE && phaseEnd) begin
         bitCnt <= '0;
      end else if (state == BIT_SPACE && phaseEnd) begin
         shift  <= {shift[30:0], 1'b0};
         bitCnt <= bitCnt + 6'd1;
      end
   end

   // Envelope and busy are registered from the upcoming state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         envReg  <= 1'b0;
         busyReg <= 1'b0;
      end else begin
         envReg  <= isMarkState(nextState);
         busyReg <= (nextState != IDLE);
      end
   end

   // Carrier restarts high at every mark entry and then toggles each half-period.
   always_ff @(posedge clk) begin
      if (rst) begin
         carrier    <= 1'b0;
         carrierCnt <= '0;
      end else if (isMarkState(nextState) && !isMarkState(state)) begin
         carrier    <= 1'b1;
         carrierCnt <= '0;
      end else if (CARRIER_HALF != 0) begin
         if (carrierCnt == 16'(CARRIER_HALF - 1)) begin
            carrier    <= ~carrier;
            carrierCnt <= '0;
         end else begin
            carrierCnt <= carrierCnt + 16'd1;
         end
      end
   end

   assign bus.irEnv = envReg;
   assign bus.irOut = (CARRIER_HALF == 0) ? envReg : (envReg & carrier);
   assign bus.busy  = busyReg;
   assign bus.done  = (state == GAP) && phaseEnd;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Testbench for ir_nec_tx: two instances share one stimulus, one unmodulated
// and one with a short carrier. Envelope run lengths are compared against a
// phase list built from the NEC framing rules.
module tb_ir_nec_tx;

   localparam int TICKS        = 4;
   localparam int CAR          = 3;
   localparam int LEAD_MARK_T  = 257;
   localparam int LEAD_SPACE_T = 128;
   localparam int REP_SPACE_T  = 64;
   localparam int BIT_MARK_T   = 16;
   localparam int ZERO_T       = 16;
   localparam int ONE_T        = 48;
   localparam int GAP_T        = 1143;

   typedef struct {
      bit level;
      int ticks;
   } phase_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   phase_t expPhases[$];
   logic [7:0] ra;
   logic [7:0] rc;

   ir_nec_tx_if bus0();
   ir_nec_tx_if bus1();

   ir_nec_tx #(.TICK_CYCLES(TICKS), .CARRIER_HALF(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   ir_nec_tx #(.TICK_CYCLES(TICKS), .CARRIER_HALF(CAR)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   always #5 clk = ~clk;

   // Watchdog so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic driveInputs(input logic st, input logic rp, input logic [7:0] a, input logic [7:0] c);
      bus0.start = st;  bus0.repeatReq = rp;  bus0.address = a;  bus0.command = c;
      bus1.start = st;  bus1.repeatReq = rp;  bus1.address = a;  bus1.command = c;
   endtask

   // Expected envelope as a list of (level, ticks) phases, excluding the gap.
   task automatic buildModel(input bit rep, input logic [7:0] a, input logic [7:0] c);
      logic [31:0] frame;
      frame = {a, ~a, c, ~c};
      expPhases.delete();
      expPhases.push_back('{level: 1'b1, ticks: LEAD_MARK_T});
      if (rep) begin
         expPhases.push_back('{level: 1'b0, ticks: REP_SPACE_T});
      end else begin
         expPhases.push_back('{level: 1'b0, ticks: LEAD_SPACE_T});
         for (int k = 31; k >= 0; k--) begin
            expPhases.push_back('{level: 1'b1, ticks: BIT_MARK_T});
            expPhases.push_back('{level: 1'b0, ticks: frame[k] ? ONE_T : ZERO_T});
         end
      end
      expPhases.push_back('{level: 1'b1, ticks: BIT_MARK_T});
   endtask

   // Pulse the request for one cycle; afterwards address/command are scrambled.
   task automatic applyStimulus(input logic st, input logic rp, input logic [7:0] a, input logic [7:0] c);
      @(negedge clk);
      driveInputs(st, rp, a, c);
      @(negedge clk);
      driveInputs(1'b0, 1'b0, 8'($urandom), 8'($urandom));
   endtask

   task automatic runFrame(input string name, input logic st, input logic rp,
                           input logic [7:0] a, input logic [7:0] c,
                           input int injPhase, input int injAt, input bit injReset);
      int          cnt;
      int          limit;
      bit          lvl;
      bit          flagsOk;
      bit          quiet;
      logic        expCar;
      logic [31:0] decoded;
      logic [31:0] expFrame;
      int          doneCnt;
      int          doneAt;
      bit          rep;

      rep      = rp && !st;
      expFrame = {a, ~a, c, ~c};
      decoded  = '0;
      buildModel(rep, a, c);
      applyStimulus(st, rp, a, c);
      checkOutput({name, "_busyRise"}, {31'd0, bus0.busy}, 32'd1);

      for (int idx = 0; idx < expPhases.size(); idx++) begin
         lvl     = expPhases[idx].level;
         limit   = expPhases[idx].ticks * TICKS + 16;
         cnt     = 0;
         flagsOk = 1'b1;
         while (bus0.irEnv === lvl && cnt < limit) begin
            expCar = lvl && (((cnt / CAR) % 2) == 0);
            if (bus1.irEnv !== lvl || bus0.irOut !== lvl || bus1.irOut !== expCar ||
                bus0.busy !== 1'b1 || bus0.done !== 1'b0)
               flagsOk = 1'b0;
            if (idx == injPhase && cnt == injAt) begin
               if (injReset) begin
                  rst = 1'b1;
                  @(negedge clk);
                  rst = 1'b0;
                  checkOutput({name, "_rstEnv"},  {31'd0, bus0.irEnv}, 32'd0);
                  checkOutput({name, "_rstBusy"}, {31'd0, bus0.busy},  32'd0);
                  checkOutput({name, "_rstDone"}, {31'd0, bus0.done},  32'd0);
                  checkOutput({name, "_rstOut"},  {31'd0, bus1.irOut}, 32'd0);
                  repeat (3) @(negedge clk);
                  checkOutput({name, "_rstIdle"}, {31'd0, bus0.busy},  32'd0);
                  return;
               end
               driveInputs(1'b1, 1'b0, 8'($urandom), 8'($urandom));
            end else begin
               driveInputs(1'b0, 1'b0, bus0.address, bus0.command);
            end
            cnt++;
            @(negedge clk);
         end
         checkOutput($sformatf("%s_ph%0d_len", name, idx), cnt, expPhases[idx].ticks * TICKS);
         checkOutput($sformatf("%s_ph%0d_flags", name, idx), {31'd0, flagsOk}, 32'd1);
         if (!rep && idx >= 3 && idx <= 65 && (idx % 2) == 1)
            decoded = {decoded[30:0], (cnt > 32 * TICKS)};
      end

      if (!rep)
         checkOutput({name, "_decoded"}, decoded, expFrame);

      cnt     = 0;
      doneCnt = 0;
      doneAt  = -1;
      quiet   = 1'b1;
      while (bus0.busy === 1'b1 && cnt < GAP_T * TICKS + 16) begin
         if (bus0.irEnv !== 1'b0 || bus0.irOut !== 1'b0 || bus1.irOut !== 1'b0)
            quiet = 1'b0;
         if (bus0.done === 1'b1) begin
            doneCnt++;
            doneAt = cnt;
         end
         if (bus1.done !== bus0.done)
            quiet = 1'b0;
         cnt++;
         @(negedge clk);
      end
      checkOutput({name, "_gapLen"},   cnt, GAP_T * TICKS);
      checkOutput({name, "_gapQuiet"}, {31'd0, quiet}, 32'd1);
      checkOutput({name, "_doneCnt"},  doneCnt, 32'd1);
      checkOutput({name, "_doneAt"},   doneAt, GAP_T * TICKS - 1);
      checkOutput({name, "_doneLow"},  {31'd0, bus0.done}, 32'd0);
      repeat (8) @(negedge clk);
      checkOutput({name, "_idleBusy"}, {31'd0, bus0.busy},  32'd0);
      checkOutput({name, "_idleEnv"},  {31'd0, bus0.irEnv}, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      driveInputs(1'b0, 1'b0, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      checkOutput("reset_irEnv", {31'd0, bus0.irEnv}, 32'd0);
      checkOutput("reset_irOut", {31'd0, bus1.irOut}, 32'd0);
      checkOutput("reset_busy",  {31'd0, bus0.busy},  32'd0);
      checkOutput("reset_done",  {31'd0, bus0.done},  32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_busy", {31'd0, bus0.busy}, 32'd0);

      runFrame("full62", 1'b1, 1'b0, 8'h00, 8'h62, -1, 0, 1'b0);

      ra = 8'($urandom);
      rc = 8'($urandom);
      runFrame("busyIgn", 1'b1, 1'b0, ra, rc, 23, 5, 1'b0);

      ra = 8'($urandom);
      rc = 8'($urandom);
      runFrame("repeat", 1'b0, 1'b1, ra, rc, -1, 0, 1'b0);

      ra = 8'($urandom);
      rc = 8'($urandom);
      runFrame("both", 1'b1, 1'b1, ra, rc, -1, 0, 1'b0);

      ra = 8'($urandom);
      rc = 8'($urandom);
      runFrame("rstMid", 1'b1, 1'b0, ra, rc, 12, 3, 1'b1);

      ra = 8'($urandom);
      rc = 8'($urandom);
      runFrame("afterRst", 1'b1, 1'b0, ra, rc, -1, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ir_nec_tx.md
Name: ir_nec_tx

Overview:
- NEC-format IR transmitter; the sending end of the remote-control link used by the debug front panel.
- Serialises one 32-bit frame from an 8-bit address and an 8-bit command, or a short repeat code.
- Drives an active-high envelope and an optional 38 kHz-modulated output to an IR LED.
- Timing uses the same 35 us slow-tick base as the existing IR receive path, so frames loop back cleanly into the team's decoder for self-test.

Parameters:
- TICK_CYCLES, 1750: clk cycles per slow tick (35 us at 50 MHz).
- LEAD_MARK_TICKS, 257: leading mark, about 9 ms.
- LEAD_SPACE_TICKS, 128: leading space, about 4.5 ms.
- REP_SPACE_TICKS, 64: repeat-code space, about 2.25 ms.
- BIT_MARK_TICKS, 16: data/stop mark, about 560 us.
- ZERO_SPACE_TICKS, 16: space for a 0 bit.
- ONE_SPACE_TICKS, 48: space for a 1 bit.
- GAP_TICKS, 1143: minimum idle after any frame, about 40 ms.
- CARRIER_HALF, 658: clk cycles per carrier half-period. 0 disables modulation, so irOut equals irEnv.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to send a full frame; sampled only in IDLE
- repeatReq  in  1  one-cycle request to send a repeat code; sampled only in IDLE, start wins if both high
- address  in  8  frame address; captured on accepted request
- command  in  8  frame command; captured on accepted request
- irEnv  out  1  registered envelope, 1 during marks
- irOut  out  1  irEnv ANDed with the carrier
- busy  out  1  high from the cycle after acceptance through the end of GAP
- done  out  1  one-cycle pulse in the last GAP cycle

Behaviour:
- Reset values: irEnv=0, irOut=0, busy=0, done=0, state=IDLE, all counters 0.
- Frame register: shift = {address, ~address, command, ~command}, loaded on accept and transmitted MSB first. The receiver therefore sees command at bits [15:8].
- States: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
- Latency: a request accepted in cycle N gives state=LEAD_MARK, irEnv=1 and busy=1 in cycle N+1.
- Phase timing:
  - Every phase lasts exactly K*TICK_CYCLES clk cycles, where K is that phase's tick count.
  - The prescaler (0..TICK_CYCLES-1) and the tick counter both clear on phase entry.
  - The phase ends on the cycle where the prescaler reaches TICK_CYCLES-1 and the tick count reaches K-1.
- Transitions:
  - IDLE -> LEAD_MARK on start or repeatReq. Latch isRepeat=repeatReq&&!start.
  - LEAD_MARK -> LEAD_SPACE.
  - LEAD_SPACE, LEAD_SPACE_TICKS, goes to BIT_MARK with bitCnt=0. If isRepeat, the space uses REP_SPACE_TICKS and goes to STOP_MARK instead.
  - BIT_MARK -> BIT_SPACE. The space length is ONE_SPACE_TICKS if shift[31]=1, else ZERO_SPACE_TICKS.
  - BIT_SPACE end: shift <<= 1 and bitCnt++. If bitCnt was 31, go to STOP_MARK, else to BIT_MARK.
  - STOP_MARK -> GAP.
  - GAP -> IDLE after GAP_TICKS. done=1 in the final GAP cycle; busy drops the following cycle.
- irEnv=1 exactly in LEAD_MARK, BIT_MARK and STOP_MARK; 0 otherwise.
- Carrier:
  - A toggle counter restarts at mark entry with phase high.
  - irOut = irEnv & carrier.
  - irOut is 0 whenever irEnv=0.
- Requests while busy are ignored and not queued.
- address and command may change after acceptance without effect.
- bitCnt is 6 bits and never exceeds 32.
- Reset mid-frame: the next cycle is fully in reset state with irEnv=0 and no done pulse.

Decomposition:
- Shared package ir_nec_pkg holds:
  - the NEC tick constants;
  - the state encoding;
  - the remote scan-code constants (CHANNEL=8'h62, CHANNEL_PLUS=8'hE2, N0=8'h68, ...), so TX and RX use one source.
- One sub-module, ir_tick_timer: prescaler plus tick counter, with a load value and a phaseEnd pulse.
- Carrier generation stays inline.

Test Plan:
- Run all tests with TICK_CYCLES=4 and CARRIER_HALF=0 unless noted.
- Full frame: start, address=8'h00, command=8'h62 -> mark/space sequence 257/128, then 32x(16 mark, 16|48 space), then 16 stop mark. Decoded bits = 0x00FF629D. done pulses once; busy falls 1143 ticks after the stop mark ends.
- Loopback: TICK_CYCLES=1750, irEnv into the existing IR decoder, command=8'hE2 -> decoder mode increments from 0 to 1.
- Repeat code: repeatReq alone -> 257 mark, 64 space, 16 mark, then GAP. start together with repeatReq -> full frame.
- Busy ignore: second start during BIT_SPACE of bit 10 -> frame unchanged, exactly one done pulse.
- Carrier: CARRIER_HALF=3 -> irOut toggles every 3 cycles, high first at each mark entry, and is 0 during every space.
- Reset mid-frame: rst in BIT_MARK of bit 5 -> next cycle irEnv=0 and busy=0. A new start then yields a clean full frame.
